// File: rtl/instruction_cache.sv
// instruction_cache
//   Direct-mapped, read-only instruction cache between the cpu fetch port and a
//   block-wide instruction memory. A hit returns the word combinationally in the
//   same cycle. A miss raises BUSYWAIT and refills the whole block from memory.
//   The fill runs through IDLE -> MEM_READ -> UPDATE.
// Ports
//   CLK, RESET     clock; synchronous active-low reset
//   PC             fetch byte address (PC[1:0] and PC[31:ADDR_W] ignored)
//   INSTRUCTION    fetched word, valid while BUSYWAIT==0
//   BUSYWAIT       stall request to the cpu
//   MEM_READ       block read request to memory
//   MEM_ADDRESS    block address {tag,index} of the outstanding miss
//   MEM_READDATA   full block; word k at [32k+31:32k]
//   MEM_BUSYWAIT   memory busy; a read completes when it is 0 at a posedge
module instruction_cache #(
    parameter int ADDR_W   = 10,
    parameter int INDEX_W  = 3,
    parameter int OFFSET_W = 2,
    // Derived from the parameters above; it must not be overridden.
    localparam int TAG_W   = ADDR_W - INDEX_W - OFFSET_W - 2
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic [31:0]                  PC,
    output logic [31:0]                  INSTRUCTION,
    output logic                         BUSYWAIT,
    output logic                         MEM_READ,
    output logic [TAG_W+INDEX_W-1:0]     MEM_ADDRESS,
    input  logic [32*(2**OFFSET_W)-1:0]  MEM_READDATA,
    input  logic                         MEM_BUSYWAIT
);
    localparam int LINES = 2 ** INDEX_W;
    localparam int BLK_W = 32 * (2 ** OFFSET_W);

    typedef enum logic [1:0] {S_IDLE, S_MEM_READ, S_UPDATE} state_t;

    state_t                    state_q, state_d;
    logic [LINES-1:0]          valid;
    logic [TAG_W-1:0]          tag_store  [LINES];
    logic [BLK_W-1:0]          data_store [LINES];
    logic [TAG_W+INDEX_W-1:0]  miss_addr;
    logic [BLK_W-1:0]          fill_data;

    logic [OFFSET_W-1:0]       offset;
    logic [INDEX_W-1:0]        index;
    logic [TAG_W-1:0]          tag;
    logic [INDEX_W-1:0]        miss_index;
    logic [TAG_W-1:0]          miss_tag;
    logic                      hit;
    logic                      unused;

    assign offset     = PC[OFFSET_W+1:2];
    assign index      = PC[INDEX_W+OFFSET_W+1:OFFSET_W+2];
    assign tag        = PC[ADDR_W-1:INDEX_W+OFFSET_W+2];
    assign unused     = ^{PC[31:ADDR_W], PC[1:0]};
    assign miss_index = miss_addr[INDEX_W-1:0];
    assign miss_tag   = miss_addr[TAG_W+INDEX_W-1:INDEX_W];

    assign hit         = valid[index] && (tag_store[index] == tag);
    assign INSTRUCTION = data_store[index][{offset, 5'd0} +: 32];
    // The fill only ever looks at miss_addr, so PC may wander during a stall.
    assign MEM_ADDRESS = miss_addr;

    always_comb begin
        state_d  = state_q;
        BUSYWAIT = 1'b0;
        MEM_READ = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!hit) begin
                    BUSYWAIT = 1'b1;
                    state_d  = S_MEM_READ;
                end
            end
            S_MEM_READ: begin
                MEM_READ = 1'b1;
                BUSYWAIT = 1'b1;
                if (!MEM_BUSYWAIT) state_d = S_UPDATE;
            end
            S_UPDATE: begin
                BUSYWAIT = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // The cpu is never stalled while the cache is held in reset.
        if (!RESET) BUSYWAIT = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q   <= S_IDLE;
            valid     <= '0;
            miss_addr <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && !hit)
                miss_addr <= {tag, index};
            if (state_q == S_MEM_READ && !MEM_BUSYWAIT)
                fill_data <= MEM_READDATA;
            // A miss evicts the indexed line unconditionally; nothing to write back.
            if (state_q == S_UPDATE)
                valid[miss_index] <= 1'b1;
        end
    end

    // Data and tag arrays need no reset; the valid bits gate them.
    always_ff @(posedge CLK) begin
        if (RESET && state_q == S_UPDATE) begin
            data_store[miss_index] <= fill_data;
            tag_store[miss_index]  <= miss_tag;
        end
    end
endmodule

// File: tb/tb_instruction_cache.sv
// Directed testbench for instruction_cache with a latency-programmable block
// memory model. Memory word k of block address a reads as 32'hC0DE_0000 | a<<8 | k.
module tb_instruction_cache;
    logic         CLK = 1'b0;
    logic         RESET;
    logic [31:0]  PC;
    logic [31:0]  INSTRUCTION;
    logic         BUSYWAIT;
    logic         MEM_READ;
    logic [5:0]   MEM_ADDRESS;
    logic [127:0] MEM_READDATA;
    logic         MEM_BUSYWAIT;

    int checks = 0;
    int errors = 0;
    int lat    = 5;
    int mem_cnt = 0;

    instruction_cache dut (
        .CLK(CLK), .RESET(RESET), .PC(PC), .INSTRUCTION(INSTRUCTION),
        .BUSYWAIT(BUSYWAIT), .MEM_READ(MEM_READ), .MEM_ADDRESS(MEM_ADDRESS),
        .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] w(input logic [5:0] a, input int k);
        return 32'hC0DE_0000 | ({26'd0, a} << 8) | k;
    endfunction

    // Memory: MEM_READ must be held for 'lat' cycles (at least one).
    always @(posedge CLK) mem_cnt <= MEM_READ ? mem_cnt + 1 : 0;
    assign MEM_BUSYWAIT = MEM_READ && ((mem_cnt + 1) < lat);
    always_comb begin
        MEM_READDATA = '0;
        for (int k = 0; k < 4; k++) MEM_READDATA[32*k +: 32] = w(MEM_ADDRESS, k);
    end

    // Applies PC at a negedge (releasing reset) and counts stall cycles until
    // BUSYWAIT falls; returns -1 busy cycles if the stall never ends.
    task automatic do_fetch(input logic [31:0] pc, output int busy, output int rd,
                            output logic [5:0] addr);
        @(negedge CLK);
        RESET = 1'b1;
        PC    = pc;
        busy  = 0;
        rd    = 0;
        addr  = '0;
        #1;
        while (BUSYWAIT && busy < 100) begin
            busy++;
            if (MEM_READ) begin rd++; addr = MEM_ADDRESS; end
            @(negedge CLK); #1;
        end
        if (BUSYWAIT) busy = -1;
    endtask

    task automatic test_reset;
        RESET = 1'b0; PC = 32'h0;
        repeat (3) @(negedge CLK);
        #1;
        checks++;
        if (BUSYWAIT !== 1'b0) begin errors++; $display("FAIL reset_busywait got %b want 0", BUSYWAIT); end
        checks++;
        if (MEM_READ !== 1'b0) begin errors++; $display("FAIL reset_mem_read got %b want 0", MEM_READ); end
    endtask

    task automatic test_cold_miss;
        int busy, rd; logic [5:0] a;
        lat = 5;
        do_fetch(32'h0, busy, rd, a);
        checks++;
        if (busy !== 7) begin errors++; $display("FAIL cold_busy got %0d want 7", busy); end
        checks++;
        if (rd !== 5) begin errors++; $display("FAIL cold_memread got %0d want 5", rd); end
        checks++;
        if (a !== 6'd0) begin errors++; $display("FAIL cold_addr got %0d want 0", a); end
        checks++;
        if (INSTRUCTION !== w(6'd0, 0)) begin errors++; $display("FAIL cold_instr got %h want %h", INSTRUCTION, w(6'd0, 0)); end
    endtask

    task automatic test_same_block_hits;
        int busy, rd; logic [5:0] a;
        for (int k = 1; k < 4; k++) begin
            do_fetch(32'(4 * k), busy, rd, a);
            checks++;
            if (busy !== 0) begin errors++; $display("FAIL hit%0d_busy got %0d want 0", k, busy); end
            checks++;
            if (MEM_READ !== 1'b0) begin errors++; $display("FAIL hit%0d_memread got %b want 0", k, MEM_READ); end
            checks++;
            if (INSTRUCTION !== w(6'd0, k)) begin errors++; $display("FAIL hit%0d_instr got %h want %h", k, INSTRUCTION, w(6'd0, k)); end
        end
    endtask

    task automatic test_conflict;
        int busy, rd; logic [5:0] a;
        lat = 3;
        do_fetch(32'h080, busy, rd, a);
        checks++;
        if (busy !== 5) begin errors++; $display("FAIL conf_busy got %0d want 5", busy); end
        checks++;
        if (a !== 6'b001000) begin errors++; $display("FAIL conf_addr got %b want 001000", a); end
        checks++;
        if (INSTRUCTION !== w(6'd8, 0)) begin errors++; $display("FAIL conf_instr got %h want %h", INSTRUCTION, w(6'd8, 0)); end
        do_fetch(32'h084, busy, rd, a);
        checks++;
        if (busy !== 0 || INSTRUCTION !== w(6'd8, 1)) begin errors++; $display("FAIL conf_hit got busy %0d instr %h want 0 %h", busy, INSTRUCTION, w(6'd8, 1)); end
        do_fetch(32'h000, busy, rd, a);
        checks++;
        if (busy !== 5 || a !== 6'd0) begin errors++; $display("FAIL conf_refill got busy %0d addr %0d want 5 0", busy, a); end
        checks++;
        if (INSTRUCTION !== w(6'd0, 0)) begin errors++; $display("FAIL conf_refill_instr got %h want %h", INSTRUCTION, w(6'd0, 0)); end
    endtask

    task automatic test_pc_wiggle;
        int busy, rd; logic [5:0] a;
        lat  = 4;
        busy = 0;
        @(negedge CLK); PC = 32'h010; #1;
        if (BUSYWAIT) busy++;
        @(negedge CLK); PC = 32'h3F4; #1;
        checks++;
        if (MEM_READ !== 1'b1 || MEM_ADDRESS !== 6'd1) begin errors++; $display("FAIL wiggle_req got rd %b addr %0d want 1 1", MEM_READ, MEM_ADDRESS); end
        if (BUSYWAIT) busy++;
        @(negedge CLK); PC = 32'h3F8; #1;
        if (BUSYWAIT) busy++;
        @(negedge CLK); PC = 32'h010; #1;
        while (BUSYWAIT && busy < 100) begin busy++; @(negedge CLK); #1; end
        checks++;
        if (busy !== 6) begin errors++; $display("FAIL wiggle_busy got %0d want 6", busy); end
        checks++;
        if (INSTRUCTION !== w(6'd1, 0)) begin errors++; $display("FAIL wiggle_instr got %h want %h", INSTRUCTION, w(6'd1, 0)); end
        do_fetch(32'h018, busy, rd, a);
        checks++;
        if (busy !== 0 || INSTRUCTION !== w(6'd1, 2)) begin errors++; $display("FAIL wiggle_hit got busy %0d instr %h want 0 %h", busy, INSTRUCTION, w(6'd1, 2)); end
        do_fetch(32'h3F4, busy, rd, a);
        checks++;
        if (busy !== 6 || a !== 6'd63) begin errors++; $display("FAIL wiggle_other got busy %0d addr %0d want 6 63", busy, a); end
        checks++;
        if (INSTRUCTION !== w(6'd63, 1)) begin errors++; $display("FAIL wiggle_other_instr got %h want %h", INSTRUCTION, w(6'd63, 1)); end
    endtask

    task automatic test_reset_mid_fill;
        int busy, rd; logic [5:0] a;
        lat = 10;
        @(negedge CLK); PC = 32'h020;
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0; #1;
        checks++;
        if (BUSYWAIT !== 1'b0 || MEM_READ !== 1'b1) begin errors++; $display("FAIL midrst_pre got busy %b rd %b want 0 1", BUSYWAIT, MEM_READ); end
        @(negedge CLK); #1;
        checks++;
        if (MEM_READ !== 1'b0 || BUSYWAIT !== 1'b0) begin errors++; $display("FAIL midrst_post got rd %b busy %b want 0 0", MEM_READ, BUSYWAIT); end
        do_fetch(32'h000, busy, rd, a);
        checks++;
        if (busy !== 12 || a !== 6'd0) begin errors++; $display("FAIL midrst_pc0 got busy %0d addr %0d want 12 0", busy, a); end
        do_fetch(32'h020, busy, rd, a);
        checks++;
        if (busy !== 12 || a !== 6'd2) begin errors++; $display("FAIL midrst_line got busy %0d addr %0d want 12 2", busy, a); end
        checks++;
        if (INSTRUCTION !== w(6'd2, 0)) begin errors++; $display("FAIL midrst_instr got %h want %h", INSTRUCTION, w(6'd2, 0)); end
    endtask

    task automatic test_zero_latency;
        int busy, rd; logic [5:0] a;
        lat = 0;
        do_fetch(32'h04C, busy, rd, a);
        checks++;
        if (busy !== 3 || rd !== 1) begin errors++; $display("FAIL zero_lat got busy %0d rd %0d want 3 1", busy, rd); end
        checks++;
        if (a !== 6'd4 || INSTRUCTION !== w(6'd4, 3)) begin errors++; $display("FAIL zero_lat_data got addr %0d instr %h want 4 %h", a, INSTRUCTION, w(6'd4, 3)); end
    endtask

    initial begin
        test_reset;
        test_cold_miss;
        test_same_block_hits;
        test_conflict;
        test_pc_wiggle;
        test_reset_mid_fill;
        test_zero_latency;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
